// File: rtl/result_packet_assembler_pkg.sv
// Shared types and helpers for the result packet assembler.
// Holds the controller state encoding and the packet-id width derivation.
package result_packet_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Packet id is at least one bit wide, even for a single-packet instruction.
  function automatic int calc_pid_width(input int num_packets);
    return (num_packets > 2) ? $clog2(num_packets) : 1;
  endfunction

endpackage

// File: rtl/result_lane_merger.sv
// Writes one packet's lanes into the accumulator at the packet's pid offset.
// Purely combinational; a pid beyond the packet range leaves the accumulator untouched.
module result_lane_merger #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 1,
  parameter int XLEN        = 32,
  parameter int PID_WIDTH   = 2
) (
  input  logic [NUM_THREADS-1:0]      acc_tmask_i,
  input  logic [NUM_THREADS*XLEN-1:0] acc_data_i,
  input  logic [NUM_LANES-1:0]        in_tmask_i,
  input  logic [NUM_LANES*XLEN-1:0]   in_data_i,
  input  logic [PID_WIDTH-1:0]        pid_i,
  output logic [NUM_THREADS-1:0]      tmask_o,
  output logic [NUM_THREADS*XLEN-1:0] data_o
);

  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;

  always_comb begin
    tmask_o = acc_tmask_i;
    data_o  = acc_data_i;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (32'(pid_i) == 32'(p)) begin
        for (int j = 0; j < NUM_LANES; j++) begin
          tmask_o[p*NUM_LANES+j]              = in_tmask_i[j];
          data_o[(p*NUM_LANES+j)*XLEN +: XLEN] = in_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/result_packet_assembler.sv
// Merges split result packets (sop..eop, by pid) into one full-width writeback for commit.
// Result valid the cycle after eop; stalls input only while holding an unaccepted result.
module result_packet_assembler
  import result_packet_assembler_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 1,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = 2,
  parameter int UUID_WIDTH  = 1,
  parameter int PC_BITS     = 32,
  parameter int NR_BITS     = 6,
  parameter int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  parameter int PID_WIDTH   = calc_pid_width(NUM_PACKETS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [PC_BITS-1:0]          in_pc,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic                        in_wb,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [PC_BITS-1:0]          out_pc,
  output logic [NR_BITS-1:0]          out_rd,
  output logic                        out_wb,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        proto_err,
  output logic [31:0]                 assembled_cnt
);

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [PC_BITS-1:0]    pc;
    logic [NR_BITS-1:0]    rd;
    logic                  wb;
  } hdr_t;

  state_e                      state_q, state_d;
  hdr_t                        hdr_q, hdr_d;
  logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
  logic [NUM_THREADS*XLEN-1:0] data_q, data_d;
  logic                        proto_err_q, proto_err_d;
  logic [31:0]                 cnt_q, cnt_d;

  hdr_t                        in_hdr;
  logic                        fire_in, fire_out, pid_bad;
  logic [NUM_THREADS-1:0]      base_tmask, merged_tmask;
  logic [NUM_THREADS*XLEN-1:0] base_data, merged_data;

  assign in_hdr    = {in_uuid, in_wid, in_pc, in_rd, in_wb};
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = (state_q != ST_FULL) || out_ready;
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = out_valid && out_ready;
  assign pid_bad   = 32'(in_pid) >= 32'(NUM_PACKETS);

  // A start-of-packet always builds on a cleared accumulator.
  assign base_tmask = in_sop ? '0 : tmask_q;
  assign base_data  = in_sop ? '0 : data_q;

  result_lane_merger #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_LANES   (NUM_LANES),
    .XLEN        (XLEN),
    .PID_WIDTH   (PID_WIDTH)
  ) u_merger (
    .acc_tmask_i (base_tmask),
    .acc_data_i  (base_data),
    .in_tmask_i  (in_tmask),
    .in_data_i   (in_data),
    .pid_i       (in_pid),
    .tmask_o     (merged_tmask),
    .data_o      (merged_data)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    tmask_d     = tmask_q;
    data_d      = data_q;
    proto_err_d = proto_err_q;
    cnt_d       = cnt_q + {31'd0, fire_out};
    if (fire_out) state_d = ST_IDLE;
    // An input can only fire in FULL when the result leaves too, so FULL acts as IDLE here.
    if (fire_in) begin
      if (pid_bad) begin
        proto_err_d = 1'b1;
      end else if (in_sop) begin
        if (state_q == ST_ACCUM) proto_err_d = 1'b1;
        hdr_d   = in_hdr;
        tmask_d = merged_tmask;
        data_d  = merged_data;
        state_d = in_eop ? ST_FULL : ST_ACCUM;
      end else if (state_q == ST_ACCUM) begin
        tmask_d = merged_tmask;
        data_d  = merged_data;
        if (in_eop) state_d = ST_FULL;
      end else begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      tmask_q     <= '0;
      data_q      <= '0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      tmask_q     <= tmask_d;
      data_q      <= data_d;
      proto_err_q <= proto_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_uuid      = hdr_q.uuid;
  assign out_wid       = hdr_q.wid;
  assign out_pc        = hdr_q.pc;
  assign out_rd        = hdr_q.rd;
  assign out_wb        = hdr_q.wb;
  assign out_tmask     = tmask_q;
  assign out_data      = data_q;
  assign proto_err     = proto_err_q;
  assign assembled_cnt = cnt_q;

endmodule

// File: tb/tb_result_packet_assembler.sv
// Randomized scoreboard bench: a 4x1-lane assembler against a packet-level model,
// plus a 4x4-lane instance streaming single-packet instructions.
module tb_result_packet_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic in_valid, in_ready, in_wb, in_sop, in_eop;
  logic [0:0] in_uuid, in_tmask;
  logic [1:0] in_wid, in_pid;
  logic [31:0] in_pc, in_data;
  logic [5:0] in_rd;
  logic out_valid, out_ready, out_wb, proto_err;
  logic [0:0] out_uuid;
  logic [1:0] out_wid;
  logic [31:0] out_pc, assembled_cnt;
  logic [5:0] out_rd;
  logic [3:0] out_tmask;
  logic [127:0] out_data;

  logic w_in_valid, w_in_ready, w_sop, w_eop, w_out_valid, w_out_ready, w_out_wb, w_proto_err;
  logic [0:0] w_in_pid, w_out_uuid;
  logic [3:0] w_in_tmask, w_out_tmask;
  logic [127:0] w_in_data, w_out_data;
  logic [1:0] w_out_wid;
  logic [31:0] w_out_pc, w_cnt;
  logic [5:0] w_out_rd;

  result_packet_assembler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_pc(in_pc), .in_rd(in_rd), .in_wb(in_wb),
    .in_tmask(in_tmask), .in_data(in_data), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
    .out_pc(out_pc), .out_rd(out_rd), .out_wb(out_wb), .out_tmask(out_tmask),
    .out_data(out_data), .proto_err(proto_err), .assembled_cnt(assembled_cnt)
  );

  result_packet_assembler #(.NUM_LANES(4)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_pc(in_pc), .in_rd(in_rd), .in_wb(in_wb),
    .in_tmask(w_in_tmask), .in_data(w_in_data), .in_pid(w_in_pid), .in_sop(w_sop), .in_eop(w_eop),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_uuid(w_out_uuid), .out_wid(w_out_wid),
    .out_pc(w_out_pc), .out_rd(w_out_rd), .out_wb(w_out_wb), .out_tmask(w_out_tmask),
    .out_data(w_out_data), .proto_err(w_proto_err), .assembled_cnt(w_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [0:0]   uuid;
    logic [1:0]   wid;
    logic [31:0]  pc;
    logic [5:0]   rd;
    logic         wb;
    logic [3:0]   tmask;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  // Reference model: an instruction is the set of lanes written between sop and eop.
  exp_t q[$];
  exp_t wq[$];
  bit m_active, m_err;
  int m_pushes;
  exp_t m_cur;
  logic m_tm[4];
  logic [31:0] m_lane[4];

  function automatic void model_reset();
    q.delete();
    m_active = 0;
    m_err = 0;
    m_pushes = 0;
  endfunction

  task automatic model_accept();
    int p;
    bit applied;
    p = int'(in_pid);
    applied = 0;
    if (in_sop) begin
      if (m_active) m_err = 1;
      m_active = 1;
      m_cur.uuid = in_uuid; m_cur.wid = in_wid; m_cur.pc = in_pc;
      m_cur.rd = in_rd; m_cur.wb = in_wb;
      for (int i = 0; i < 4; i++) begin m_tm[i] = 0; m_lane[i] = 0; end
      applied = 1;
    end else if (!m_active) begin
      m_err = 1;
    end else begin
      applied = 1;
    end
    if (applied) begin
      m_tm[p] = in_tmask[0];
      m_lane[p] = in_data;
      if (in_eop) begin
        for (int i = 0; i < 4; i++) begin
          m_cur.tmask[i] = m_tm[i];
          m_cur.data[i*32 +: 32] = m_lane[i];
        end
        m_cur.cyc = cyc;
        q.push_back(m_cur);
        m_active = 0;
        m_pushes++;
      end
    end
  endtask

  task automatic set_hdr();
    in_uuid = 1'($urandom_range(0, 1));
    in_wid = 2'($urandom_range(0, 3));
    in_pc = $urandom();
    in_rd = 6'($urandom_range(0, 63));
    in_wb = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input bit sop, input bit eop, input logic [1:0] pid,
                      input logic tm, input logic [31:0] d);
    bit ok;
    ok = 0;
    in_valid = 1; in_sop = sop; in_eop = eop; in_pid = pid; in_tmask = tm; in_data = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 0;
    end else begin
      @(posedge clk); #1;
      model_accept();
      in_valid = 0;
    end
  endtask

  bit rnd_ordy = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: every presented result is checked against the head of its queue.
  bit presenting = 0, w_presenting = 0;
  int w_fires = 0;
  exp_t e, we;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      presenting = 0;
      w_presenting = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 128'(out_valid), 128'(0));
        else begin
          e = q[0];
          if (!presenting) chk("latency", 128'(cyc), 128'(e.cyc));
          chk("out_uuid", 128'(out_uuid), 128'(e.uuid));
          chk("out_wid", 128'(out_wid), 128'(e.wid));
          chk("out_pc", 128'(out_pc), 128'(e.pc));
          chk("out_rd", 128'(out_rd), 128'(e.rd));
          chk("out_wb", 128'(out_wb), 128'(e.wb));
          chk("out_tmask", 128'(out_tmask), 128'(e.tmask));
          chk("out_data", out_data, e.data);
          presenting = 1;
          if (out_ready) begin void'(q.pop_front()); presenting = 0; end
        end
      end
      if (w_out_valid) begin
        if (wq.size() == 0) chk("w_spurious_out", 128'(w_out_valid), 128'(0));
        else begin
          we = wq[0];
          if (!w_presenting) chk("w_latency", 128'(cyc), 128'(we.cyc));
          chk("w_out_uuid", 128'(w_out_uuid), 128'(we.uuid));
          chk("w_out_pc", 128'(w_out_pc), 128'(we.pc));
          chk("w_out_tmask", 128'(w_out_tmask), 128'(we.tmask));
          chk("w_out_data", w_out_data, we.data);
          w_presenting = 1;
          if (w_out_ready) begin void'(wq.pop_front()); w_presenting = 0; w_fires++; end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int n;
    int pids[$];
    reset = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_pid = 0; in_tmask = 0; in_data = 0;
    out_ready = 1; w_in_valid = 0; w_sop = 1; w_eop = 1; w_in_pid = 0; w_in_tmask = 0;
    w_in_data = 0; w_out_ready = 1;
    set_hdr();
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_proto_err", 128'(proto_err), 128'(0));
    chk("rst_cnt", 128'(assembled_cnt), 128'(0));
    chk("rst_tmask", 128'(out_tmask), 128'(0));
    chk("rst_data", out_data, 128'(0));
    chk("rst_hdr", {out_uuid, out_wid, out_pc, out_rd, out_wb}, 128'(0));
    @(posedge clk); #1;

    // Full four-packet instruction.
    set_hdr();
    send(1, 0, 0, 1, 32'h10); send(0, 0, 1, 1, 32'h11);
    send(0, 0, 2, 1, 32'h12); send(0, 1, 3, 1, 32'h13);
    // Sparse: only pids 1 and 3.
    set_hdr();
    send(1, 0, 1, 1, 32'hA1);
    set_hdr();
    send(0, 1, 3, 1, 32'hA3);
    repeat (2) @(posedge clk); #1;

    // Backpressure with the next sop waiting.
    out_ready = 0;
    set_hdr();
    send(1, 0, 0, 1, 32'hB0); send(0, 1, 2, 0, 32'hB2);
    set_hdr();
    in_valid = 1; in_sop = 1; in_eop = 0; in_pid = 0; in_tmask = 1; in_data = 32'hC0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    model_accept();
    in_valid = 0;
    @(negedge clk);
    chk("bp_cnt", 128'(assembled_cnt), 128'(m_pushes));
    @(posedge clk); #1;
    send(0, 1, 3, 1, 32'hC3);

    // Protocol errors: orphan packet, then restart mid-instruction.
    repeat (2) @(posedge clk); #1;
    send(0, 0, 2, 1, 32'hDEAD);
    @(negedge clk);
    chk("err_idle_flag", 128'(proto_err), 128'(m_err));
    chk("err_idle_no_out", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    set_hdr(); in_uuid = 0;
    send(1, 0, 0, 1, 32'hE0); send(0, 0, 1, 1, 32'hE1);
    set_hdr(); in_uuid = 1;
    send(1, 0, 0, 1, 32'hF0); send(0, 1, 3, 1, 32'hF3);
    repeat (3) @(posedge clk); #1;
    chk("err_cnt", 128'(assembled_cnt), 128'(m_pushes));
    chk("err_sticky", 128'(proto_err), 128'(m_err));

    // Reset in the middle of an instruction.
    set_hdr();
    send(1, 0, 0, 1, 32'h50); send(0, 0, 1, 1, 32'h51);
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_cnt", 128'(assembled_cnt), 128'(0));
    chk("mid_rst_proto_err", 128'(proto_err), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_tmask", 128'(out_tmask), 128'(0));
    @(posedge clk); #1;

    // Random instructions with random pid subsets and random commit backpressure.
    rnd_ordy = 1;
    for (int k = 0; k < 60; k++) begin
      pids.delete();
      n = $urandom_range(1, 15);
      for (int p = 0; p < 4; p++) if (n[p]) pids.push_back(p);
      for (int i = 0; i < pids.size(); i++) begin
        set_hdr();
        send(i == 0, i == pids.size() - 1, 2'(pids[i]), 1'($urandom_range(0, 1)), $urandom());
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    rnd_ordy = 0;
    out_ready = 1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 128'(q.size()), 128'(0));
    @(negedge clk);
    chk("rand_cnt", 128'(assembled_cnt), 128'(m_pushes));
    chk("rand_proto_err", 128'(proto_err), 128'(m_err));

    // Wide instance: 100 back-to-back single-packet instructions.
    @(posedge clk); #1;
    for (int k = 0; k < 100; k++) begin
      set_hdr();
      w_in_valid = 1;
      w_in_tmask = 4'($urandom_range(0, 15));
      w_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      we.uuid = in_uuid; we.wid = in_wid; we.pc = in_pc; we.rd = in_rd; we.wb = in_wb;
      we.tmask = w_in_tmask; we.data = w_in_data; we.cyc = cyc + 1;
      wq.push_back(we);
      @(negedge clk);
      chk("w_in_ready", 128'(w_in_ready), 128'(1));
      @(posedge clk); #1;
    end
    w_in_valid = 0;
    repeat (3) @(negedge clk);
    chk("w_fires", 128'(w_fires), 128'(100));
    chk("w_cnt", 128'(w_cnt), 128'(100));
    chk("w_proto_err", 128'(w_proto_err), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_packet_assembler.md
# result_packet_assembler

Reassembles the NUM_LANES-wide result packets that a functional unit returns from a split-dispatched instruction (packet id, start-of-packet and end-of-packet tagged) into one NUM_THREADS-wide result. Sits between a functional unit's result output and the commit stage, so commit always sees one full-width writeback per instruction. One instance per execute block.

## Interface
- NUM_THREADS, 4: threads per warp; output width.
- NUM_LANES, 1: lanes per input packet; NUM_THREADS divisible by NUM_LANES.
- XLEN, 32: data width per lane.
- NW_WIDTH, 2: warp id width.
- UUID_WIDTH, 1: instruction uuid width.
- PC_BITS, 32; NR_BITS, 6: pc and rd widths.
- Derived: NUM_PACKETS = NUM_THREADS/NUM_LANES; PID_WIDTH = max(1, clog2(NUM_PACKETS)).

- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-low: state clears on a rising clk edge while reset==0.
- in_valid  in  1  packet valid.
- in_ready  out  1  packet accepted when in_valid && in_ready.
- in_uuid, in_wid, in_pc, in_rd, in_wb  in  UUID_WIDTH / NW_WIDTH / PC_BITS / NR_BITS / 1  header fields.
- in_tmask  in  NUM_LANES  active lanes of this packet.
- in_data  in  NUM_LANES*XLEN  lane results, lane 0 in LSBs.
- in_pid, in_sop, in_eop  in  PID_WIDTH / 1 / 1  packet id, first, last.
- out_valid  out  1  assembled result valid.
- out_ready  in  1  commit accepts.
- out_uuid, out_wid, out_pc, out_rd, out_wb  out  same widths as inputs.
- out_tmask  out  NUM_THREADS; out_data  out  NUM_THREADS*XLEN.
- proto_err  out  1  sticky protocol-error flag.
- assembled_cnt  out  32  count of out fires, wraps.

## Operation
- States: IDLE (no partial result), ACCUM (sop received, awaiting eop), FULL (out_valid=1).
- in_ready = (state != FULL) || out_ready.
- Accepted packet with in_sop: clear accumulator tmask and data to 0, latch header, write lanes, go to ACCUM (or FULL if in_eop also set).
- Accepted non-sop packet in ACCUM: write lanes pid*NUM_LANES .. pid*NUM_LANES+NUM_LANES-1 (tmask and data); header not re-latched; in_eop -> FULL.
- Lane write: accumulator bit/word at lane k overwritten with in_tmask[j]/in_data[j] for all j (inactive lanes write tmask 0, data as given).
- Protocol errors (set proto_err, held until reset): sop while ACCUM (restart from new packet, old partial discarded); non-sop packet in IDLE (dropped, state stays IDLE); in_pid >= NUM_PACKETS (packet dropped, state unchanged).
- FULL: outputs driven from accumulator; on out fire go IDLE, or, if a packet fires in the same cycle, handle it as from IDLE (sop -> ACCUM/FULL, else error-drop). assembled_cnt += 1 per out fire.
- NUM_LANES == NUM_THREADS: every packet is sop&&eop, pid ignored (PID_WIDTH 1, must be 0).

## Timing
- Reset values: out_valid 0, in_ready 1, proto_err 0, assembled_cnt 0, state IDLE, out_tmask 0, out_data 0, header outputs 0.
- Latency: out_valid rises the cycle after the eop packet fires; minimum 1 cycle for single-packet instructions.
- Throughput: one packet per cycle including FULL-with-out_ready; back-to-back single-packet instructions sustain 1/cycle.
- Output fields stable while out_valid && !out_ready.
- Reset mid-ACCUM or mid-FULL: partial/complete result discarded, no output fire.

## Structure
- Shared package: PID_WIDTH/NUM_PACKETS derivation function, 2-bit state enum (IDLE, ACCUM, FULL), header struct (uuid, wid, pc, rd, wb).
- One sub-module natural: result_lane_merger, combinational write of one packet's lanes into the accumulator at pid offset; controller and counters stay in top.

## Test plan
- NUM_THREADS=4, NUM_LANES=1: pids 0..3, sop on 0, eop on 3, data 0x10..0x13 -> one out fire, out_data {0x13,0x12,0x11,0x10}, tmask 4'b1111, 1 cycle after eop.
- Sparse: pids 1 (sop) and 3 (eop) only, tmask 1 each -> out_tmask 4'b1010, lanes 0,2 data 0.
- Backpressure: out_ready=0 for 5 cycles in FULL with next sop pending -> in_ready=0, outputs stable; out_ready=1 -> out fire and new sop accepted same cycle, assembled_cnt increments by 1.
- Errors: non-sop packet in IDLE -> dropped, proto_err=1; sop during ACCUM -> restart, result carries new uuid only.
- Reset=0 for one cycle in ACCUM after 2 packets -> IDLE, out_valid 0, assembled_cnt 0, proto_err 0.
- NUM_LANES=NUM_THREADS=4: 100 back-to-back sop&&eop packets, out_ready=1 -> 100 fires at 1/cycle, assembled_cnt=100.
